// File: rtl/motor_cmd_sequencer.sv
// Queues motor move commands and issues them one at a time to the six-axis
// pulse generator, tracking busy for completion and enforcing an enable-low gap.
module motor_cmd_sequencer #(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned START_TO = 8,
   parameter int unsigned HOLD     = 2,
   parameter int unsigned GAP      = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [2:0]               cmd_motor,
   input  logic [9:0]               cmd_pulses,
   input  logic                     abort,
   input  logic                     busy,
   output logic [2:0]               motor,
   output logic                     enable,
   output logic [9:0]               pulse_num,
   output logic                     done,
   output logic                     err,
   output logic                     idle,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int unsigned PW    = $clog2(DEPTH);
   localparam int unsigned CW    = PW + 1;
   localparam int unsigned TMAX0 = (START_TO > HOLD) ? START_TO : HOLD;
   localparam int unsigned TMAX  = (TMAX0 > GAP) ? TMAX0 : GAP;
   localparam int unsigned TW    = $clog2(TMAX + 1) + 1;

   typedef struct packed {
      logic [2:0] motor;
      logic [9:0] pulses;
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      GAPW  = 3'd4
   } state_t;

   cmd_t            mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            push_c, pop_c;
   cmd_t            head_c;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [2:0]      motor_q, motor_d;
   logic [9:0]      pulse_q, pulse_d;
   logic            enable_q, enable_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            idle_q, idle_d;

   // FIFO handshake; abort blocks any push in the flush cycle
   assign cmd_ready = (count_q < CW'(DEPTH)) && !abort;
   assign push_c    = cmd_valid && cmd_ready;
   assign head_c    = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (abort) begin
         count_d = '0;
      end else if (push_c && !pop_c) begin
         count_d = CW'(count_q + 1'b1);
      end else if (!push_c && pop_c) begin
         count_d = CW'(count_q - 1'b1);
      end
   end

   // Storage has no reset; only entries between the pointers are ever read
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= cmd_t'{motor: cmd_motor, pulses: cmd_pulses};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push_c) wr_ptr_q <= PW'(wr_ptr_q + 1'b1);
            if (pop_c)  rd_ptr_q <= PW'(rd_ptr_q + 1'b1);
         end
      end
   end

   // Sequencer next-state; one shared timer serves start timeout, hold and gap
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      motor_d = motor_q;
      pulse_d = pulse_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      pop_c   = 1'b0;

      if (abort) begin
         state_d = GAPW;
         timer_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (count_q != '0) begin
                  pop_c   = 1'b1;
                  motor_d = head_c.motor;
                  pulse_d = head_c.pulses;
                  if (head_c.motor > 3'd5) begin
                     err_d = 1'b1;
                  end else if (head_c.pulses == 10'd0) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = LOAD;
                  end
               end
            end
            LOAD: begin
               state_d = RUN;
               timer_d = '0;
            end
            RUN: begin
               if (busy) begin
                  state_d = DRAIN;
                  timer_d = '0;
               end else if (timer_q == TW'(START_TO - 1)) begin
                  err_d   = 1'b1;
                  state_d = GAPW;
                  timer_d = '0;
               end else begin
                  timer_d = TW'(timer_q + 1'b1);
               end
            end
            DRAIN: begin
               if (busy) begin
                  timer_d = '0;
               end else if (timer_q == TW'(HOLD)) begin
                  done_d  = 1'b1;
                  state_d = GAPW;
                  timer_d = '0;
               end else begin
                  timer_d = TW'(timer_q + 1'b1);
               end
            end
            GAPW: begin
               if (timer_q == TW'(GAP - 1)) begin
                  state_d = IDLE;
                  timer_d = '0;
               end else begin
                  timer_d = TW'(timer_q + 1'b1);
               end
            end
            default: begin
               state_d = IDLE;
               timer_d = '0;
            end
         endcase
      end

      enable_d = (state_d == RUN) || (state_d == DRAIN);
      idle_d   = (state_d == IDLE) && (count_d == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         motor_q  <= '0;
         pulse_q  <= '0;
         enable_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         idle_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         motor_q  <= motor_d;
         pulse_q  <= pulse_d;
         enable_q <= enable_d;
         done_q   <= done_d;
         err_q    <= err_d;
         idle_q   <= idle_d;
      end
   end

   assign motor      = motor_q;
   assign pulse_num  = pulse_q;
   assign enable     = enable_q;
   assign done       = done_q;
   assign err        = err_q;
   assign idle       = idle_q;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed bench for motor_cmd_sequencer with a simple busy-flag generator model.
module tb_motor_cmd_sequencer;

   localparam int unsigned DEPTH    = 8;
   localparam int unsigned START_TO = 8;
   localparam int unsigned HOLD     = 2;
   localparam int unsigned GAP      = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_motor;
   logic [9:0]  cmd_pulses;
   logic        abort;
   logic        busy;
   logic [2:0]  motor;
   logic        enable;
   logic [9:0]  pulse_num;
   logic        done;
   logic        err;
   logic        idle;
   logic [$clog2(DEPTH):0] fifo_count;

   int checks   = 0;
   int failures = 0;

   // generator model: busy rises the cycle after enable is seen, lasts bm_len cycles
   int   bm_len;
   int   bm_cnt;
   logic en_prev;
   logic bm_used;

   motor_cmd_sequencer #(
      .DEPTH(DEPTH), .START_TO(START_TO), .HOLD(HOLD), .GAP(GAP)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_motor(cmd_motor), .cmd_pulses(cmd_pulses), .abort(abort), .busy(busy),
      .motor(motor), .enable(enable), .pulse_num(pulse_num), .done(done),
      .err(err), .idle(idle), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (!rst) begin
         busy    = 1'b0;
         bm_cnt  = 0;
         bm_used = 1'b0;
         en_prev = 1'b0;
      end else begin
         if (busy) begin
            bm_cnt--;
            if (bm_cnt <= 0) busy = 1'b0;
         end else if (en_prev && enable && !bm_used && bm_len > 0) begin
            busy    = 1'b1;
            bm_cnt  = bm_len;
            bm_used = 1'b1;
         end
         if (!enable) bm_used = 1'b0;
         en_prev = enable;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int rises;
      int low;
      logic prev;

      rst = 1'b0; cmd_valid = 1'b0; cmd_motor = '0; cmd_pulses = '0;
      abort = 1'b0; busy = 1'b0;
      bm_len = 0; bm_cnt = 0; en_prev = 1'b0; bm_used = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_enable", enable, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_idle", idle, 1);
      chk("rst_count", fifo_count, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_motor", motor, 0);
      chk("rst_pulse", pulse_num, 0);
      rst = 1'b1;
      step();

      // single command, motor 2, 5 pulses, busy 10 cycles
      bm_len = 10;
      cmd_valid = 1'b1; cmd_motor = 3'd2; cmd_pulses = 10'd5;
      chk("t1_ready", cmd_ready, 1);
      step();
      cmd_valid = 1'b0;
      chk("t1_count1", fifo_count, 1);
      chk("t1_en_e0", enable, 0);
      step();
      chk("t1_motor", motor, 2);
      chk("t1_pulse", pulse_num, 5);
      chk("t1_en_e1", enable, 0);
      chk("t1_count0", fifo_count, 0);
      chk("t1_idle_busy", idle, 0);
      step();
      chk("t1_en_e2", enable, 1);
      n = 0;
      do begin step(); n++; end while (!done && n < 60);
      chk("t1_done_lat", n, 14);
      chk("t1_en_off", enable, 0);
      chk("t1_err", err, 0);
      step();
      chk("t1_done_once", done, 0);
      chk("t1_idle_gap", idle, 0);
      step();
      chk("t1_idle_end", idle, 1);

      // invalid motor then zero pulses
      cmd_valid = 1'b1; cmd_motor = 3'd7; cmd_pulses = 10'd4;
      step();
      cmd_motor = 3'd1; cmd_pulses = 10'd0;
      step();
      cmd_valid = 1'b0;
      chk("t3_err", err, 1);
      chk("t3_done0", done, 0);
      chk("t3_en_a", enable, 0);
      step();
      chk("t3_done", done, 1);
      chk("t3_err0", err, 0);
      chk("t3_en_b", enable, 0);
      chk("t3_idle_a", idle, 1);
      step();
      chk("t3_done_clr", done, 0);
      chk("t3_en_c", enable, 0);
      chk("t3_idle_b", idle, 1);

      // start timeout, then next queued command proceeds
      bm_len = 0;
      cmd_valid = 1'b1; cmd_motor = 3'd4; cmd_pulses = 10'd7;
      step();
      cmd_motor = 3'd5; cmd_pulses = 10'd9;
      step();
      cmd_valid = 1'b0;
      step();
      chk("t4_en", enable, 1);
      chk("t4_motor", motor, 4);
      n = 0;
      do begin step(); n++; end while (!err && n < 40);
      chk("t4_to_lat", n, START_TO);
      chk("t4_en_off", enable, 0);
      chk("t4_no_done", done, 0);
      bm_len = 3;
      n = 0;
      do begin step(); n++; end while (!enable && n < 40);
      chk("t4_next_lat", n, GAP + 2);
      chk("t4_next_motor", motor, 5);
      chk("t4_next_pulse", pulse_num, 9);
      n = 0;
      do begin step(); n++; end while (!done && n < 60);
      chk("t4_next_done", done, 1);
      n = 0;
      do begin step(); n++; end while (!idle && n < 20);
      chk("t4_idle", idle, 1);

      // burst: fill FIFO behind a long-running command
      bm_len = 40;
      cmd_valid = 1'b1; cmd_motor = 3'd3; cmd_pulses = 10'd100;
      step();
      cmd_valid = 1'b0;
      step();
      step();
      chk("t2_a_en", enable, 1);
      for (int i = 0; i < 8; i++) begin
         cmd_valid = 1'b1; cmd_motor = 3'(i % 6); cmd_pulses = 10'(i + 1);
         step();
      end
      cmd_motor = 3'd5; cmd_pulses = 10'd99;
      chk("t2_ready_full", cmd_ready, 0);
      chk("t2_count_full", fifo_count, DEPTH);
      step();
      chk("t2_count_hold", fifo_count, DEPTH);
      cmd_valid = 1'b0;
      bm_len = 3;
      rises = 0; low = 0; prev = 1'b1; n = 0;
      while (n < 800 && !(rises == 8 && idle)) begin
         step();
         n++;
         if (enable && !prev) begin
            chk($sformatf("t2_motor%0d", rises), motor, rises % 6);
            chk($sformatf("t2_pulse%0d", rises), pulse_num, rises + 1);
            chk($sformatf("t2_gap%0d", rises), low, GAP + 2);
            rises++;
         end
         if (!enable) low++;
         else low = 0;
         prev = enable;
      end
      chk("t2_rises", rises, 8);
      chk("t2_idle", idle, 1);

      // abort mid-RUN with three queued
      bm_len = 0;
      cmd_valid = 1'b1; cmd_motor = 3'd0; cmd_pulses = 10'd10;
      step();
      cmd_motor = 3'd1; cmd_pulses = 10'd11;
      step();
      cmd_motor = 3'd2; cmd_pulses = 10'd12;
      step();
      cmd_motor = 3'd3; cmd_pulses = 10'd13;
      step();
      chk("t5_en", enable, 1);
      chk("t5_count", fifo_count, 3);
      abort = 1'b1; cmd_motor = 3'd4; cmd_pulses = 10'd14;
      #1;
      chk("t5_ready", cmd_ready, 0);
      step();
      abort = 1'b0; cmd_valid = 1'b0;
      chk("t5_en_off", enable, 0);
      chk("t5_count0", fifo_count, 0);
      chk("t5_done_a", done, 0);
      chk("t5_err_a", err, 0);
      chk("t5_idle_a", idle, 0);
      step();
      chk("t5_idle_b", idle, 0);
      chk("t5_done_b", done, 0);
      step();
      chk("t5_idle_c", idle, 1);
      chk("t5_done_c", done, 0);
      chk("t5_count_c", fifo_count, 0);

      // reset mid-DRAIN
      bm_len = 20;
      cmd_valid = 1'b1; cmd_motor = 3'd5; cmd_pulses = 10'd20;
      step();
      cmd_motor = 3'd1; cmd_pulses = 10'd2;
      step();
      cmd_valid = 1'b0;
      repeat (5) step();
      chk("t6_pre_en", enable, 1);
      chk("t6_pre_count", fifo_count, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_en", enable, 0);
      chk("t6_done", done, 0);
      chk("t6_err", err, 0);
      chk("t6_count", fifo_count, 0);
      chk("t6_idle", idle, 1);
      chk("t6_ready", cmd_ready, 1);
      busy = 1'b0;
      step();
      rst = 1'b1;
      step();
      bm_len = 2;
      cmd_valid = 1'b1; cmd_motor = 3'd0; cmd_pulses = 10'd3;
      step();
      cmd_valid = 1'b0;
      step();
      chk("t6_post_en0", enable, 0);
      step();
      chk("t6_post_en", enable, 1);
      chk("t6_post_motor", motor, 0);
      chk("t6_post_pulse", pulse_num, 3);
      n = 0;
      do begin step(); n++; end while (!done && n < 60);
      chk("t6_post_done", done, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
